mux_ctrl: RTL



---
 rtl/mux_pkg.sv | 13 +
 rtl/mux_ctrl_sync_cell.sv | 23 ++
 rtl/mux_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the project mux and its control stage.
package mux_pkg;

    localparam int ADDR_W   = 5;
    localparam int NUM_PROJ = 24;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        GUARD = 2'd1,
        ON    = 2'd2
    } mux_ctrl_state_t;

endpackage

// File: rtl/mux_ctrl_sync_cell.sv
// Single-bit multi-flop synchronizer for an asynchronous chip-pad input.
module sync_cell #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/mux_ctrl.sv
// Project mux control: synchronizes the select pads, counts increments into an
// address and gates the enable with a guard interval after every address change.
module mux_ctrl #(
    parameter int ADDR_W       = mux_pkg::ADDR_W,
    parameter int NUM_PROJ     = mux_pkg::NUM_PROJ,
    parameter int SYNC_STAGES  = 2,
    parameter int GUARD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel_rst_n_i,
    input  logic              sel_inc_i,
    input  logic              ena_i,
    output logic [ADDR_W-1:0] addr,
    output logic              ena,
    output logic              busy
);

    import mux_pkg::*;

    localparam int                CNT_W      = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [ADDR_W:0]   NUM_PROJ_X = (ADDR_W + 1)'(NUM_PROJ);

    logic [2:0]        w_pad;
    logic [2:0]        w_pad_s;

    logic              r_inc_prev;
    logic              r_inc_rise;
    logic              r_clr;
    logic              r_en;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_addr_chg;
    logic              w_valid;

    mux_ctrl_state_t   r_state;
    mux_ctrl_state_t   w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_ena;
    logic              r_busy;

    assign w_pad = {ena_i, sel_inc_i, sel_rst_n_i};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            sync_cell #(
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .i_d   (w_pad[gi]),
                .o_q   (w_pad_s[gi])
            );
        end
    endgenerate

    // One decode register after the synchronizers so that every pad event
    // lands on addr and the FSM exactly SYNC_STAGES+1 edges after sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inc_prev <= 1'b0;
            r_inc_rise <= 1'b0;
            r_clr      <= 1'b0;
            r_en       <= 1'b0;
        end else begin
            r_inc_prev <= w_pad_s[1];
            r_inc_rise <= w_pad_s[1] & ~r_inc_prev;
            r_clr      <= ~w_pad_s[0];
            r_en       <= w_pad_s[2];
        end
    end

    always_comb begin
        w_addr_next = r_addr;
        if (r_clr) begin
            w_addr_next = '0;
        end else if (r_inc_rise) begin
            w_addr_next = r_addr + 1'b1;
        end
    end

    assign w_addr_chg = (w_addr_next != r_addr);
    assign w_valid    = ({1'b0, r_addr} < NUM_PROJ_X) & ~r_clr;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            OFF: begin
                if (r_en && w_valid && !w_addr_chg) begin
                    w_state_next = GUARD;
                    w_cnt_next   = '0;
                end
            end
            GUARD: begin
                if (!r_en || !w_valid) begin
                    w_state_next = OFF;
                end else if (w_addr_chg) begin
                    w_cnt_next = '0;
                end else if (r_cnt == GUARD_LAST) begin
                    w_state_next = ON;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ON: begin
                if (!r_en || !w_valid) begin
                    w_state_next = OFF;
                end else if (w_addr_chg) begin
                    w_state_next = GUARD;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = OFF;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state and address, with no path from the pads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_state <= OFF;
            r_cnt   <= '0;
            r_ena   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_addr  <= w_addr_next;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ena   <= (w_state_next == ON);
            r_busy  <= (w_state_next == GUARD);
        end
    end

    assign addr = r_addr;
    assign ena  = r_ena;
    assign busy = r_busy;

endmodule
